// File: rtl/capture_uart_readout.sv
// capture_uart_readout
//   Drains the per-channel ADC capture FIFO once the capture stage reports
//   a full, frozen buffer. The samples go out as a single 8N1 UART frame:
//   HEADER, CH_ID, data bytes, TRAILER, checksum (8-bit sum of the data bytes).
//   Afterwards the capture stage is re-armed with a one-cycle cap_bg pulse.
//
// Ports
//   Clk         system clock
//   Reset_n     asynchronous active-low reset
//   enable      1 = keep acquiring frames, 0 = stop after the current frame
//   cap_end     capture stage reports FIFO filled and frozen
//   fifo_empty  FIFO empty flag
//   fifo_q      FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdreq  FIFO read request, single-cycle pulses
//   cap_bg      one-cycle re-arm pulse to the capture stage
//   uart_tx     serial output, idles high
//   busy        high from frame start until re-arm or return to IDLE
//   frame_done  one-cycle pulse at the end of the checksum stop bit
//   sample_cnt  data bytes sent in the current/last frame
//
// State      | meaning
// IDLE       | readout stopped, waiting for enable
// WAIT_END   | armed, waiting for cap_end
// HDR        | sending HEADER
// CHID       | sending CH_ID
// RD_REQ     | issue one FIFO read, or finish data when empty / at cap
// RD_LAT     | FIFO read latency, latch fifo_q
// SEND       | sending one data byte
// TRL        | sending TRAILER
// CKS        | sending checksum
// REARM      | pulse cap_bg (enable=1) or drop to IDLE
// WAIT_CLR   | wait for cap_end to fall so a stale buffer is not re-sent
module capture_uart_readout #(
  parameter int unsigned CLK_DIV     = 434,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [7:0]  TRAILER     = 8'h5A,
  parameter logic [7:0]  CH_ID       = 8'h00,
  parameter int unsigned MAX_SAMPLES = 4096
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        enable,
  input  logic        cap_end,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_q,
  output logic        fifo_rdreq,
  output logic        cap_bg,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done,
  output logic [12:0] sample_cnt
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [12:0] MAX_CNT    = 13'(MAX_SAMPLES);

  typedef enum logic [3:0] {
    IDLE, WAIT_END, HDR, CHID, RD_REQ, RD_LAT, SEND, TRL, CKS, REARM, WAIT_CLR
  } state_t;

  state_t      state, state_n;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_active;
  logic        tx_issued;
  logic        send_ok;
  logic [15:0] bit_tmr;
  logic [3:0]  bits_left;
  logic [8:0]  tx_shift;
  logic [7:0]  data_reg;
  logic [7:0]  checksum;

  // Byte transmitter. bit_tmr counts down the cycles of the current bit,
  // bits_left counts the bits still to follow it (start bit loads 9).
  // tx_shift holds the remaining data bits with the stop bit on top.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_active <= 1'b0;
      bit_tmr   <= '0;
      bits_left <= '0;
      tx_shift  <= '1;
      uart_tx   <= 1'b1;
    end else if (!tx_active) begin
      if (tx_start) begin
        tx_active <= 1'b1;
        bit_tmr   <= BIT_RELOAD;
        bits_left <= 4'd9;
        tx_shift  <= {1'b1, tx_data};
        uart_tx   <= 1'b0;
      end
    end else if (bit_tmr != 16'd0) begin
      bit_tmr <= bit_tmr - 16'd1;
    end else if (bits_left == 4'd0) begin
      tx_active <= 1'b0;
      uart_tx   <= 1'b1;
    end else begin
      uart_tx   <= tx_shift[0];
      tx_shift  <= {1'b1, tx_shift[8:1]};
      bits_left <= bits_left - 4'd1;
      bit_tmr   <= BIT_RELOAD;
    end
  end

  assign tx_done = tx_active && (bit_tmr == 16'd0) && (bits_left == 4'd0);

  // A sending state fires tx_start once; tx_issued blocks a second start
  // until that byte's tx_done moves the FSM on.
  assign send_ok = !tx_issued && !tx_active;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      tx_issued  <= 1'b0;
      data_reg   <= '0;
      checksum   <= '0;
      sample_cnt <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_n;

      if (tx_done)
        tx_issued <= 1'b0;
      else if (tx_start)
        tx_issued <= 1'b1;

      if (state == RD_LAT)
        data_reg <= fifo_q;

      if (state == WAIT_END && enable && cap_end) begin
        checksum   <= '0;
        sample_cnt <= '0;
        busy       <= 1'b1;
      end else if (state == SEND && tx_start) begin
        checksum   <= checksum + data_reg;
        sample_cnt <= sample_cnt + 13'd1;
      end else if (state == REARM) begin
        busy <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n    = state;
    tx_start   = 1'b0;
    tx_data    = HEADER;
    fifo_rdreq = 1'b0;
    cap_bg     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_n = WAIT_END;
      end
      WAIT_END: begin
        if (!enable)      state_n = IDLE;
        else if (cap_end) state_n = HDR;
      end
      HDR: begin
        tx_data  = HEADER;
        tx_start = send_ok;
        if (tx_done) state_n = CHID;
      end
      CHID: begin
        tx_data  = CH_ID;
        tx_start = send_ok;
        if (tx_done) state_n = RD_REQ;
      end
      RD_REQ: begin
        if (fifo_empty || sample_cnt == MAX_CNT) begin
          state_n = TRL;
        end else begin
          fifo_rdreq = 1'b1;
          state_n    = RD_LAT;
        end
      end
      RD_LAT: begin
        state_n = SEND;
      end
      SEND: begin
        tx_data  = data_reg;
        tx_start = send_ok;
        if (tx_done) state_n = RD_REQ;
      end
      TRL: begin
        tx_data  = TRAILER;
        tx_start = send_ok;
        if (tx_done) state_n = CKS;
      end
      CKS: begin
        tx_data  = checksum;
        tx_start = send_ok;
        if (tx_done) begin
          frame_done = 1'b1;
          state_n    = REARM;
        end
      end
      REARM: begin
        if (enable) begin
          cap_bg  = 1'b1;
          state_n = WAIT_CLR;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_CLR: begin
        if (!cap_end) state_n = WAIT_END;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_capture_uart_readout.sv
module tb_capture_uart_readout;

  localparam int CLK_DIV = 4;

  logic        Clk;
  logic        Reset_n;
  logic        enable;
  logic        cap_end;
  logic        fifo_empty;
  logic [7:0]  fifo_q;
  logic        fifo_rdreq;
  logic        cap_bg;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  logic [12:0] sample_cnt;

  capture_uart_readout #(
    .CLK_DIV(CLK_DIV), .HEADER(8'hA5), .TRAILER(8'h5A), .CH_ID(8'h00),
    .MAX_SAMPLES(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .cap_end(cap_end),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .cap_bg(cap_bg), .uart_tx(uart_tx), .busy(busy),
    .frame_done(frame_done), .sample_cnt(sample_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // FIFO model: the bench appends at wr_ptr, the DUT consumes at rd_ptr.
  logic [7:0] fifo_mem [256];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  logic flush_req = 1'b0;
  assign fifo_empty = (rd_ptr >= wr_ptr);

  always @(posedge Clk) begin
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rdreq) begin
      fifo_q <= fifo_mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Pulse counters, only ever incremented here.
  int rd_cnt = 0, cb_cnt = 0, fd_cnt = 0, viol = 0;
  always @(negedge Clk) begin
    if (fifo_rdreq) rd_cnt <= rd_cnt + 1;
    if (fifo_rdreq && fifo_empty) viol <= viol + 1;
    if (cap_bg) cb_cnt <= cb_cnt + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  // UART decoder, samples mid-bit.
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] mon_b;
  int         mon_st;
  always begin
    @(negedge Clk);
    if (uart_tx == 1'b0) begin
      mon_st = cyc;
      repeat (CLK_DIV / 2) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge Clk);
        mon_b[i] = uart_tx;
      end
      repeat (CLK_DIV) @(negedge Clk);
      rx_q.push_back(mon_b);
      rx_cyc.push_back(mon_st);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    @(negedge Clk);
    flush_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic wait_frame(input string nm, output int fdc, output logic busy_at);
    bit ok;
    ok = 0;
    fdc = 0;
    busy_at = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge Clk);
      if (frame_done) begin
        ok = 1;
        fdc = cyc;
        busy_at = busy;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_frame_timeout actual=none required=frame_done", nm);
    end
  endtask

  task automatic wait_capbg(input string nm, output int cbc);
    bit ok;
    ok = 0;
    cbc = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge Clk);
      if (cap_bg) begin
        ok = 1;
        cbc = cyc;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_capbg_timeout actual=none required=cap_bg", nm);
    end
  endtask

  task automatic expect_rx(input string nm, input int base, input logic [95:0] exp, input int len);
    logic [95:0] e;
    e = exp;
    chk({nm, "_len"}, rx_q.size() - base, len);
    for (int i = 0; i < len; i++)
      if (base + i < rx_q.size())
        chk($sformatf("%s_b%0d", nm, i), {24'd0, rx_q[base + i]}, {24'd0, e[8*i +: 8]});
  endtask

  typedef struct {
    int          n_load;
    logic [95:0] load;
    int          exp_len;
    logic [95:0] exp_b;
    int          exp_cnt;
    int          exp_rd;
    int          exp_left;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rx, base_rd, base_cb, base_fd, fdc, cbc, lows, rds, busys, n;
    logic busy_at;
    logic [95:0] ld;

    vecs[0] = '{3,  96'hF02010,               7, 96'h205AF0201000A5,   3, 3, 0};
    vecs[1] = '{0,  96'h0,                    4, 96'h005A00A5,         0, 0, 0};
    vecs[2] = '{10, 96'h01010101010101010101, 8, 96'h045A0101010100A5, 4, 4, 6};
    vecs[3] = '{1,  96'hFF,                   5, 96'hFF5AFF00A5,       1, 1, 0};
    vecs[4] = '{2,  96'h9080,                 6, 96'h105A908000A5,     2, 2, 0};

    Reset_n = 1'b0;
    enable  = 1'b0;
    cap_end = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rdreq", fifo_rdreq, 0);
    chk("rst_cap_bg", cap_bg, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    Reset_n = 1'b1;

    lows = 0; rds = 0; busys = 0;
    repeat (100) begin
      @(negedge Clk);
      if (!uart_tx) lows++;
      if (fifo_rdreq) rds++;
      if (busy) busys++;
    end
    chk("idle_uart_low_cycles", lows, 0);
    chk("idle_rdreq_cycles", rds, 0);
    chk("idle_busy_cycles", busys, 0);

    // Table-driven frames, enable held high.
    enable = 1'b1;
    for (int v = 0; v < 5; v++) begin
      base_rx = rx_q.size();
      base_rd = rd_cnt;
      base_cb = cb_cnt;
      base_fd = fd_cnt;
      ld = vecs[v].load;
      for (int i = 0; i < vecs[v].n_load; i++) load_byte(ld[8*i +: 8]);
      @(negedge Clk);
      cap_end = 1'b1;
      wait_frame($sformatf("v%0d", v), fdc, busy_at);
      chk($sformatf("v%0d_busy_in_frame", v), busy_at, 1);
      wait_capbg($sformatf("v%0d", v), cbc);
      chk($sformatf("v%0d_capbg_after_fd", v), (cbc == fdc + 1), 1);
      repeat (4) @(negedge Clk);
      expect_rx($sformatf("v%0d", v), base_rx, vecs[v].exp_b, vecs[v].exp_len);
      chk($sformatf("v%0d_sample_cnt", v), sample_cnt, vecs[v].exp_cnt);
      chk($sformatf("v%0d_rdreq", v), rd_cnt - base_rd, vecs[v].exp_rd);
      chk($sformatf("v%0d_left", v), wr_ptr - rd_ptr, vecs[v].exp_left);
      chk($sformatf("v%0d_fd_pulses", v), fd_cnt - base_fd, 1);
      chk($sformatf("v%0d_cb_pulses", v), cb_cnt - base_cb, 1);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      if (v == 0 && rx_q.size() > base_rx) begin
        n = fdc - rx_cyc[base_rx] + 1;
        chk("v0_frame_min_cycles", (n >= 70 * CLK_DIV), 1);
        chk("v0_frame_max_cycles", (n <= 70 * CLK_DIV + 20), 1);
      end
      do_flush();
      cap_end = 1'b0;
      repeat (3) @(negedge Clk);
    end

    // cap_end left high after re-arm: no stale re-read until it toggles.
    base_rd = rd_cnt;
    load_byte(8'h05);
    load_byte(8'h06);
    @(negedge Clk);
    cap_end = 1'b1;
    wait_frame("stale", fdc, busy_at);
    wait_capbg("stale", cbc);
    base_rx = rx_q.size();
    lows = 0; busys = 0;
    load_byte(8'h07);
    base_rd = rd_cnt;
    repeat (200) begin
      @(negedge Clk);
      if (!uart_tx) lows++;
      if (busy) busys++;
    end
    chk("stale_uart_low_cycles", lows, 0);
    chk("stale_busy_cycles", busys, 0);
    chk("stale_rdreq", rd_cnt - base_rd, 0);
    cap_end = 1'b0;
    repeat (3) @(negedge Clk);
    cap_end = 1'b1;
    wait_frame("rearm", fdc, busy_at);
    wait_capbg("rearm", cbc);
    repeat (4) @(negedge Clk);
    expect_rx("rearm", base_rx, 96'h075A0700A5, 5);
    cap_end = 1'b0;
    repeat (3) @(negedge Clk);

    // enable dropped during the 2nd data byte.
    base_rx = rx_q.size();
    base_cb = cb_cnt;
    load_byte(8'h11);
    load_byte(8'h22);
    load_byte(8'h33);
    @(negedge Clk);
    cap_end = 1'b1;
    n = 0;
    while (sample_cnt != 13'd2 && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    chk("endrop_reach_2nd_byte", (n < 2000), 1);
    enable = 1'b0;
    wait_frame("endrop", fdc, busy_at);
    repeat (30) @(negedge Clk);
    expect_rx("endrop", base_rx, 96'h665A33221100A5, 7);
    chk("endrop_cap_bg", cb_cnt - base_cb, 0);
    chk("endrop_busy", busy, 0);
    chk("endrop_sample_cnt", sample_cnt, 3);
    lows = 0;
    repeat (50) begin
      @(negedge Clk);
      if (!uart_tx) lows++;
    end
    chk("endrop_idle_low_cycles", lows, 0);
    cap_end = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge Clk);

    // Reset during the start bit of the first data byte.
    load_byte(8'h41);
    load_byte(8'h42);
    load_byte(8'h43);
    @(negedge Clk);
    cap_end = 1'b1;
    n = 0;
    while (!(sample_cnt == 13'd1 && !uart_tx) && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    chk("rstmid_reach_start_bit", (n < 2000), 1);
    Reset_n = 1'b0;
    #1;
    chk("rstmid_uart_tx", uart_tx, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_sample_cnt", sample_cnt, 0);
    cap_end = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    do_flush();
    repeat (60) @(negedge Clk);
    base_rx = rx_q.size();
    load_byte(8'h33);
    load_byte(8'h44);
    @(negedge Clk);
    cap_end = 1'b1;
    wait_frame("rstmid", fdc, busy_at);
    repeat (4) @(negedge Clk);
    expect_rx("rstmid", base_rx, 96'h775A443300A5, 6);
    chk("rstmid_frame_sample_cnt", sample_cnt, 2);
    cap_end = 1'b0;
    repeat (5) @(negedge Clk);

    chk("rdreq_while_empty", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
